stat_stream_accumulator: RTL and testbench

Sequential streaming front end for the calculator's statistics path. Accepts a handshaked stream of signed 16-bit samples forming one data set, tracks running sum, maximum and minimum, and on the set's last sample computes the mean with a multi-cycle divider. It presents mean/max/min/count as one held result word set. It extends the two-operand mean/max/min operation to N-sample sets and sits between operand entry and the result display mux.

---
 rtl/stat_pkg.sv | 15 +
 rtl/stat_seq_divider.sv | 77 +++++++
 rtl/stat_stream_accumulator.sv | 129 ++++++++++++
 tb/tb_stat_stream_accumulator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// Shared types and defaults for the statistics path: FSM states, default
// sample geometry and the result-word width used by all statistics units.
package stat_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    OUTPUT
  } stat_state_t;

  localparam int STAT_DATA_W = 16;
  localparam int STAT_MAX_N  = 256;
  localparam int RESULT_W    = 32;

endpackage

// File: rtl/stat_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The start edge
// already retires the first bit, so a full quotient takes SUM_W edges.
module stat_seq_divider #(
  parameter int SUM_W = 24,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int ITER_W = $clog2(SUM_W);

  logic [CNT_W-1:0]  rem_q, div_q;
  logic [SUM_W-1:0]  dq_q;
  logic [ITER_W-1:0] iter_q;

  logic [CNT_W-1:0]  rem_in, rem_out, dsr;
  logic [SUM_W-1:0]  dq_in, dq_out;
  logic [CNT_W:0]    trial;

  // One restoring step; dividend bits shift out of dq while quotient bits
  // shift in, so dq holds the quotient after the final step.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rem_out = '0;
    dq_out  = '0;
    rem_in  = start ? '0       : rem_q;
    dq_in   = start ? dividend : dq_q;
    dsr     = start ? divisor  : div_q;
    trial   = {rem_in, dq_in[SUM_W-1]};
    if (trial >= {1'b0, dsr}) begin
      rem_out = CNT_W'(trial - {1'b0, dsr});
      dq_out  = {dq_in[SUM_W-2:0], 1'b1};
    end else begin
      rem_out = trial[CNT_W-1:0];
      dq_out  = {dq_in[SUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      rem_q  <= '0;
      div_q  <= '0;
      dq_q   <= '0;
      iter_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= rem_out;
        dq_q   <= dq_out;
        div_q  <= divisor;
        iter_q <= ITER_W'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        rem_q  <= rem_out;
        dq_q   <= dq_out;
        iter_q <= iter_q + 1'b1;
        if (iter_q == ITER_W'(SUM_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = dq_q;

endmodule

// File: rtl/stat_stream_accumulator.sv
// Streaming N-sample statistics: running sum/max/min over a handshaked set,
// then a sequential mean divide, presenting a held result word set.
module stat_stream_accumulator
  import stat_pkg::*;
#(
  parameter int DATA_W = STAT_DATA_W,
  parameter int MAX_N  = STAT_MAX_N,
  parameter int CNT_W  = $clog2(MAX_N + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RESULT_W-1:0]      out_mean,
  output logic [RESULT_W-1:0]      out_max,
  output logic [RESULT_W-1:0]      out_min,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_truncated
);

  localparam int SUM_W = DATA_W + $clog2(MAX_N);

  stat_state_t state_q, state_d;

  logic signed [SUM_W:0]    sum_q, sum_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] max_q, min_q;
  logic                     trunc_q;

  logic                     hs, close;
  logic [SUM_W-1:0]         div_dividend, div_quotient;
  logic                     div_busy, div_done;
  logic signed [RESULT_W-1:0] q_ext, mean_d;

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == OUTPUT);

  assign hs      = in_valid && in_ready;
  assign sum_d   = sum_q + {{(SUM_W + 1 - DATA_W){in_data[DATA_W-1]}}, in_data};
  assign count_d = count_q + 1'b1;
  assign close   = hs && (in_last || count_d == CNT_W'(MAX_N));

  // The divider starts on the closing edge from the post-update sum/count.
  assign div_dividend = sum_d[SUM_W] ? SUM_W'(-sum_d) : SUM_W'(sum_d);

  stat_seq_divider #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (close),
    .dividend (div_dividend),
    .divisor  (count_d),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Sum stays intact through DIVIDE, so its sign drives the fix-up.
  assign q_ext  = RESULT_W'(div_quotient);
  assign mean_d = sum_q[SUM_W] ? -q_ext : q_ext;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (close)                  state_d = DIVIDE;
      DIVIDE:  if (div_done && !div_busy)  state_d = OUTPUT;
      OUTPUT:  if (out_ready)              state_d = ACCUM;
      default:                             state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q         <= '0;
      count_q       <= '0;
      max_q         <= '0;
      min_q         <= '0;
      trunc_q       <= 1'b0;
      out_mean      <= '0;
      out_max       <= '0;
      out_min       <= '0;
      out_count     <= '0;
      out_truncated <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: if (hs) begin
          sum_q   <= sum_d;
          count_q <= count_d;
          // An empty count marks the first sample of a set.
          if (count_q == '0) begin
            max_q <= in_data;
            min_q <= in_data;
          end else begin
            if (in_data > max_q) max_q <= in_data;
            if (in_data < min_q) min_q <= in_data;
          end
          if (close) trunc_q <= !in_last;
        end
        DIVIDE: if (div_done) begin
          out_mean      <= mean_d;
          out_max       <= RESULT_W'(max_q);
          out_min       <= RESULT_W'(min_q);
          out_count     <= count_q;
          out_truncated <= trunc_q;
        end
        OUTPUT: if (out_ready) begin
          sum_q   <= '0;
          count_q <= '0;
          max_q   <= '0;
          min_q   <= '0;
          trunc_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stat_stream_accumulator.sv
// Scoreboard bench: stimulus pushes hand-computed results, a negedge monitor
// pops and compares each presented result on its output handshake.
module tb_stat_stream_accumulator;

  typedef struct {
    logic [31:0] mean_v;
    logic [31:0] max_v;
    logic [31:0] min_v;
    logic [8:0]  count_v;
    logic        trunc_v;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_mean, out_max, out_min;
  logic [8:0]         out_count;
  logic               out_truncated;

  int vectors     = 0;
  int miscompares = 0;

  exp_t               sb[$];
  exp_t               mon_e;
  logic signed [15:0] stim[$];

  stat_stream_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mean      (out_mean),
    .out_max       (out_max),
    .out_min       (out_min),
    .out_count     (out_count),
    .out_truncated (out_truncated)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every result that is actually taken by the consumer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("mean",      out_mean,               mon_e.mean_v);
        check("max",       out_max,                mon_e.max_v);
        check("min",       out_min,                mon_e.min_v);
        check("count",     {23'b0, out_count},     {23'b0, mon_e.count_v});
        check("truncated", {31'b0, out_truncated}, {31'b0, mon_e.trunc_v});
      end
    end
  end

  task automatic push_sample(input logic signed [15:0] v, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called #1 after the closing edge; out_valid must first show after 24 more edges.
  task automatic wait_result(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 200);
    check({tag, "_latency"}, k, 32'd25);
    if (out_valid) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_set(input string tag, input exp_t e, input bit use_last);
    sb.push_back(e);
    for (int i = 0; i < stim.size(); i++)
      push_sample(stim[i], use_last && (i == stim.size() - 1));
    wait_result(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   k;
    bit   seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    check("in_ready_during_rst", {31'b0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},      32'd1);
    check("rst_out_valid", {31'b0, out_valid},     32'd0);
    check("rst_mean",      out_mean,               32'd0);
    check("rst_max",       out_max,                32'd0);
    check("rst_min",       out_min,                32'd0);
    check("rst_count",     {23'b0, out_count},     32'd0);
    check("rst_trunc",     {31'b0, out_truncated}, 32'd0);
    @(posedge clk);
    #1;

    // {4, 8}
    stim = '{16'sd4, 16'sd8};
    e = '{32'd6, 32'd8, 32'd4, 9'd2, 1'b0};
    run_set("set_4_8", e, 1'b1);

    // {-3, -4}: -7/2 truncates toward zero
    stim = '{-16'sd3, -16'sd4};
    e = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 9'd2, 1'b0};
    run_set("set_neg", e, 1'b1);

    // single most-negative sample
    stim = '{-16'sd32768};
    e = '{32'hFFFF_8000, 32'hFFFF_8000, 32'hFFFF_8000, 9'd1, 1'b0};
    run_set("set_single", e, 1'b1);

    // 256 x 32767 without in_last: closes at MAX_N, truncated
    e = '{32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF, 9'd256, 1'b1};
    sb.push_back(e);
    for (int i = 0; i < 256; i++) push_sample(16'sd32767, 1'b0);
    // 257th sample offered immediately and held; consumer stalls
    in_valid  = 1'b1;
    in_data   = 16'sd1;
    in_last   = 1'b0;
    out_ready = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      check("div_in_ready", {31'b0, in_ready}, 32'd0);
    end while (!out_valid && k < 200);
    check("full_latency", k, 32'd25);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid",    {31'b0, out_valid},     32'd1);
      check("hold_in_ready", {31'b0, in_ready},      32'd0);
      check("hold_mean",     out_mean,               32'h0000_7FFF);
      check("hold_count",    {23'b0, out_count},     32'd256);
      check("hold_trunc",    {31'b0, out_truncated}, 32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    // {1, 2, 3}: the held 257th sample opens this set
    stim = '{16'sd1, 16'sd2, 16'sd3};
    e = '{32'd2, 32'd3, 32'd1, 9'd3, 1'b0};
    run_set("set_1_2_3", e, 1'b1);

    // reset during DIVIDE: result must never appear
    push_sample(16'sd100, 1'b0);
    push_sample(16'sd200, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", {31'b0, seen},         32'd0);
    check("abort_mean",     out_mean,              32'd0);
    check("abort_max",      out_max,               32'd0);
    check("abort_count",    {23'b0, out_count},    32'd0);
    check("abort_in_ready", {31'b0, in_ready},     32'd1);
    @(posedge clk);
    #1;

    // {10, -20} after the aborted set
    stim = '{16'sd10, -16'sd20};
    e = '{32'hFFFF_FFFB, 32'd10, 32'hFFFF_FFEC, 9'd2, 1'b0};
    run_set("set_after_rst", e, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
